// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution datapath.
package conv_pkg;

  localparam int N_SAMPLES = 8;
  localparam int SAMPLE_W  = 8;
  localparam int CNT_W     = $clog2(2 * N_SAMPLES);
  localparam int IDX_W     = $clog2(N_SAMPLES);
  localparam int FRAME_W   = N_SAMPLES * SAMPLE_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    PRESENT,
    DRAIN
  } state_e;

endpackage

// File: rtl/conv_input_loader_if.sv
// Sample stream in, parallel frame out, between upstream, loader and convolution core.
interface conv_input_loader_if;
  import conv_pkg::*;

  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_data;
  logic                s_last;
  logic [FRAME_W-1:0]  sig1_out;
  logic [FRAME_W-1:0]  sig2_out;
  logic                frame_valid;
  logic                frame_ready;
  logic                err_frame;
  logic [7:0]          frame_count;

  modport master (
    output s_valid, s_data, s_last, frame_ready,
    input  s_ready, sig1_out, sig2_out, frame_valid, err_frame, frame_count
  );

  modport slave (
    input  s_valid, s_data, s_last, frame_ready,
    output s_ready, sig1_out, sig2_out, frame_valid, err_frame, frame_count
  );

endinterface

// File: rtl/conv_sample_bank.sv
// N_SAMPLES x SAMPLE_W register file, indexed write, whole contents read as one flat vector.
module conv_sample_bank
  import conv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [IDX_W-1:0]    idx_i,
  input  logic [SAMPLE_W-1:0] wdata_i,
  output logic [FRAME_W-1:0]  rdata_o
);

  logic [SAMPLE_W-1:0] mem_q [N_SAMPLES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_SAMPLES; k++) mem_q[k] <= '0;
    end else if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  for (genvar g = 0; g < N_SAMPLES; g++) begin : g_rd
    assign rdata_o[g*SAMPLE_W +: SAMPLE_W] = mem_q[g];
  end

endmodule

// File: rtl/conv_input_loader.sv
// Collects two N-sample signals from a serial stream and presents them as one held frame.
//   state   | meaning
//   IDLE    | out of reset, moves to LOAD_A on the next edge
//   LOAD_A  | filling bank 1 (beats 0..N-1)
//   LOAD_B  | filling bank 2 (beats N..2N-1)
//   PRESENT | frame held on sig1/sig2 until the core takes it
//   DRAIN   | discarding beats up to s_last after a missing-s_last error
module conv_input_loader
  import conv_pkg::*;
(
  input logic               clk,
  input logic               rst,
  conv_input_loader_if.slave bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [7:0]         fcnt_q, fcnt_d;
  logic               beat;
  logic               we_a, we_b;
  logic [IDX_W-1:0]   idx_a, idx_b;

  assign beat  = bus.s_valid && bus.s_ready;
  assign idx_a = IDX_W'(cnt_q);
  assign idx_b = IDX_W'(cnt_q - CNT_W'(N_SAMPLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    fcnt_d  = fcnt_q;
    we_a    = 1'b0;
    we_b    = 1'b0;
    case (state_q)
      IDLE: state_d = LOAD_A;
      LOAD_A: begin
        if (beat) begin
          we_a = 1'b1;
          if (bus.s_last) begin
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N_SAMPLES - 1)) state_d = LOAD_B;
          end
        end
      end
      LOAD_B: begin
        if (beat) begin
          we_b = 1'b1;
          if (cnt_q == CNT_W'(2 * N_SAMPLES - 1)) begin
            cnt_d = '0;
            if (bus.s_last) begin
              state_d = PRESENT;
            end else begin
              state_d = DRAIN;
              err_d   = 1'b1;
            end
          end else if (bus.s_last) begin
            state_d = LOAD_A;
            err_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      PRESENT: begin
        if (bus.frame_ready) begin
          fcnt_d  = fcnt_q + 8'd1;
          state_d = LOAD_A;
        end
      end
      DRAIN: begin
        // leave silently; the error was already flagged on entry
        if (beat && bus.s_last) state_d = LOAD_A;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.s_ready     = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == DRAIN);
  assign bus.frame_valid = (state_q == PRESENT);
  assign bus.err_frame   = err_q;
  assign bus.frame_count = fcnt_q;

  conv_sample_bank u_bank_a (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we_a),
    .idx_i   (idx_a),
    .wdata_i (bus.s_data),
    .rdata_o (bus.sig1_out)
  );

  conv_sample_bank u_bank_b (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we_b),
    .idx_i   (idx_b),
    .wdata_i (bus.s_data),
    .rdata_o (bus.sig2_out)
  );

endmodule

// File: tb/tb_conv_input_loader.sv
// Randomised bench for conv_input_loader against a frame-level reference model.
module tb_conv_input_loader;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  conv_input_loader_if bus ();

  conv_input_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // stimulus beats {last, data}; model state
  logic [8:0]         stim_q [$];
  logic [7:0]         m_q [$];
  logic               m_drain, m_pending, m_err;
  logic [7:0]         m_fcnt;
  logic [FRAME_W-1:0] m_sig1, m_sig2;
  int                 pres_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    stim_q.delete();
    m_drain   = 1'b0;
    m_pending = 1'b0;
    m_err     = 1'b0;
    m_fcnt    = 8'd0;
    m_sig1    = '0;
    m_sig2    = '0;
    pres_cnt  = 0;
  endtask

  task automatic model_beat(input logic [7:0] d, input logic last);
    if (m_drain) begin
      if (last) m_drain = 1'b0;
    end else begin
      m_q.push_back(d);
      if (m_q.size() == 2 * N_SAMPLES) begin
        if (last) begin
          for (int k = 0; k < N_SAMPLES; k++) begin
            m_sig1[k*SAMPLE_W +: SAMPLE_W] = m_q[k];
            m_sig2[k*SAMPLE_W +: SAMPLE_W] = m_q[k + N_SAMPLES];
          end
          m_pending = 1'b1;
        end else begin
          m_err   = 1'b1;
          m_drain = 1'b1;
        end
        m_q.delete();
      end else if (last) begin
        m_err = 1'b1;
        m_q.delete();
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 64'(bus.s_ready), 64'd0);
    chk({tag, "_frame_valid"}, 64'(bus.frame_valid), 64'd0);
    chk({tag, "_err_frame"}, 64'(bus.err_frame), 64'd0);
    chk({tag, "_frame_count"}, 64'(bus.frame_count), 64'd0);
    chk({tag, "_sig1"}, bus.sig1_out, 64'd0);
    chk({tag, "_sig2"}, bus.sig2_out, 64'd0);
  endtask

  task automatic cycle(input int gap_pct, input int bp_len);
    logic       beat, acc;
    logic [8:0] h;
    h = '0;
    if (stim_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
      h = stim_q[0];
      bus.s_valid = 1'b1;
      bus.s_data  = h[7:0];
      bus.s_last  = h[8];
    end else begin
      bus.s_valid = 1'b0;
      bus.s_data  = 8'($urandom);
      bus.s_last  = 1'($urandom);
    end
    if (bus.frame_valid) begin
      bus.frame_ready = (pres_cnt >= bp_len);
      pres_cnt++;
    end else begin
      pres_cnt = 0;
      bus.frame_ready = 1'($urandom);
    end
    beat = bus.s_valid && bus.s_ready;
    acc  = bus.frame_valid && bus.frame_ready;
    @(posedge clk);
    #1;
    m_err = 1'b0;
    if (beat) begin
      void'(stim_q.pop_front());
      model_beat(h[7:0], h[8]);
    end
    if (acc) begin
      m_pending = 1'b0;
      m_fcnt    = m_fcnt + 8'd1;
    end
    chk("err_frame", 64'(bus.err_frame), 64'(m_err));
    chk("frame_valid", 64'(bus.frame_valid), 64'(m_pending));
    chk("s_ready", 64'(bus.s_ready), 64'(!m_pending));
    chk("frame_count", 64'(bus.frame_count), 64'(m_fcnt));
    if (m_pending) begin
      chk("sig1_out", bus.sig1_out, m_sig1);
      chk("sig2_out", bus.sig2_out, m_sig2);
    end
  endtask

  task automatic run(input int gap_pct, input int bp_len);
    int n;
    n = 0;
    while ((stim_q.size() > 0 || m_pending) && n < 3000) begin
      cycle(gap_pct, bp_len);
      n++;
    end
    if (n >= 3000) begin
      tests++;
      fails++;
      $display("FAIL run_timeout observed=%0d pending_beats expected=0", stim_q.size());
    end
    repeat (3) cycle(gap_pct, bp_len);
  endtask

  task automatic push_nominal();
    logic [7:0] d;
    for (int k = 1; k <= N_SAMPLES; k++) begin
      d = 8'(k);
      stim_q.push_back({1'b0, d});
    end
    for (int k = 1; k <= N_SAMPLES; k++) begin
      d = 8'(-k);
      stim_q.push_back({k == N_SAMPLES, d});
    end
  endtask

  task automatic push_rand(input int n, input logic last_on_final);
    for (int k = 0; k < n; k++)
      stim_q.push_back({(k == n - 1) && last_on_final, 8'($urandom)});
  endtask

  task automatic push_rand_frame(input int kind);
    case (kind)
      0: push_rand(2 * N_SAMPLES, 1'b1);
      1: push_rand($urandom_range(1, 2 * N_SAMPLES - 1), 1'b1);
      default: begin
        push_rand(2 * N_SAMPLES, 1'b0);
        push_rand($urandom_range(1, 4), 1'b1);
      end
    endcase
  endtask

  initial begin
    bus.s_valid     = 1'b0;
    bus.s_data      = '0;
    bus.s_last      = 1'b0;
    bus.frame_ready = 1'b0;
    model_reset();

    #12;
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("idle_s_ready", 64'(bus.s_ready), 64'd0);

    // nominal frame with frame_ready freely high
    push_nominal();
    run(0, 0);
    chk("nominal_frame_count", 64'(bus.frame_count), 64'd1);

    // backpressure: core holds off for 10 cycles
    push_rand_frame(0);
    run(0, 10);

    // early s_last on beat 5, then a good frame
    push_rand(6, 1'b1);
    push_rand_frame(0);
    run(0, 0);

    // missing s_last, three junk beats, then a good frame
    push_rand(2 * N_SAMPLES, 1'b0);
    push_rand(3, 1'b1);
    push_nominal();
    run(0, 2);

    // gapped valid on the nominal frame
    push_nominal();
    run(50, 0);

    // random mix of good and malformed frames
    repeat (16) begin
      push_rand_frame($urandom_range(0, 2));
      run($urandom_range(0, 60), $urandom_range(0, 5));
    end

    // reset after beat 10
    push_rand(10, 1'b0);
    run(30, 0);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(posedge clk);
    #1;
    check_reset_vals("midrst_hold");
    rst = 1'b0;
    model_reset();
    chk("midrst_idle_s_ready", 64'(bus.s_ready), 64'd0);
    push_nominal();
    run(20, 3);
    chk("post_rst_frame_count", 64'(bus.frame_count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
